vram_write_scheduler: RTL

- Sits between the CPU bus and the background VRAM arrays: pattern memory background (PMB) and nametable (NTBL).
- Accepts CPU byte writes at any time and buffers them in a small FIFO.
- Drains the FIFO one write per clock, only while the video timing reports `writable`, so the scanline datapath never sees VRAM change mid-visible-line.
- Decodes each drained address into per-array write strobes.

---
 rtl/vram_write_scheduler.sv | 98 +++++++++
 1 files changed

// File: rtl/vram_write_scheduler.sv
// CPU-to-VRAM write buffer: queues CPU byte writes and drains them one per
// clock while video timing reports a safe update window.
module vram_write_scheduler #(
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 12,
   parameter int DATA_W = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cpu_valid,
   input  logic [ADDR_W-1:0]        cpu_addr,
   input  logic [DATA_W-1:0]        cpu_data,
   output logic                     cpu_ready,
   input  logic                     writable,
   output logic [ADDR_W-1:0]        vram_addr,
   output logic [DATA_W-1:0]        vram_data,
   output logic                     pmb_we,
   output logic                     ntbl_we,
   output logic                     other_we,
   output logic [$clog2(DEPTH):0]   pending,
   output logic [15:0]              stall_cycles
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0]     FULL   = CW'(DEPTH);
   localparam logic [ADDR_W-1:0] PMB_HI = ADDR_W'('h1FF);
   localparam logic [ADDR_W-1:0] NT_LO  = ADDR_W'('h400);
   localparam logic [ADDR_W-1:0] NT_HI  = ADDR_W'('h7FF);

   logic [ADDR_W-1:0] addr_mem_q [DEPTH];
   logic [DATA_W-1:0] data_mem_q [DEPTH];

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [15:0]   stall_q, stall_d;

   logic empty, push, pop;
   logic in_pmb, in_ntbl;

   always_comb begin
      empty     = (count_q == '0);
      cpu_ready = (count_q != FULL);
      push      = cpu_valid && cpu_ready;
      pop       = writable && !empty;

      wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

      count_d = count_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      stall_d = stall_q;
      if (cpu_valid && !cpu_ready && stall_q != 16'hFFFF)
         stall_d = stall_q + 16'd1;
   end

   // Head entry is exposed even outside the window; zero only when empty.
   always_comb begin
      vram_addr = empty ? '0 : addr_mem_q[rd_ptr_q];
      vram_data = empty ? '0 : data_mem_q[rd_ptr_q];
      in_pmb    = (vram_addr <= PMB_HI);
      in_ntbl   = (vram_addr >= NT_LO) && (vram_addr <= NT_HI);
      pmb_we    = pop && in_pmb;
      ntbl_we   = pop && in_ntbl;
      other_we  = pop && !in_pmb && !in_ntbl;
   end

   always_ff @(posedge clk) begin
      if (push) begin
         addr_mem_q[wr_ptr_q] <= cpu_addr;
         data_mem_q[wr_ptr_q] <= cpu_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         stall_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         stall_q  <= stall_d;
      end
   end

   assign pending      = count_q;
   assign stall_cycles = stall_q;

endmodule
